// File: rtl/ysyx_041461_div_iter_if.sv
// Divider handshake between the EXE stage (master) and the iterative divider (slave).
// Handshake: master pulses DIV_valid_in for one cycle with operands and mode; the
// slave accepts it only while idle (no ready, a pulse while busy is dropped) and
// answers with a single-cycle DIV_valid_out, quotient/remainder held afterwards.
interface ysyx_041461_div_iter_if;
  logic        DIV_valid_in;
  logic        DIV_signed;
  logic        DIV_divw;
  logic [63:0] DIV_dividend;
  logic [63:0] DIV_divisor;
  logic        DIV_valid_out;
  logic [63:0] DIV_quotient;
  logic [63:0] DIV_remainder;
  logic [1:0]  dbg_state;

  modport master (
    output DIV_valid_in, DIV_signed, DIV_divw, DIV_dividend, DIV_divisor,
    input  DIV_valid_out, DIV_quotient, DIV_remainder, dbg_state
  );

  modport slave (
    input  DIV_valid_in, DIV_signed, DIV_divw, DIV_dividend, DIV_divisor,
    output DIV_valid_out, DIV_quotient, DIV_remainder, dbg_state
  );
endinterface

// File: rtl/ysyx_041461_div_iter.sv
// Iterative radix-2 restoring divider for RV64 DIV/DIVU/REM/REMU and W variants.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
module ysyx_041461_div_iter (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_041461_div_iter_if.slave       div
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [5:0]  cnt;
  logic [63:0] rem;
  logic [63:0] quo;
  logic [63:0] dsr_mag;
  logic        neg_q;
  logic        neg_r;
  logic        divw_r;
  logic [63:0] q_r;
  logic [63:0] r_r;

  // operand normalisation, evaluated on the incoming operands
  logic [63:0] dvd_ext;
  logic [63:0] dsr_ext;
  logic        dvd_neg;
  logic        dsr_neg;
  logic [63:0] dvd_mag_in;
  logic [63:0] dsr_mag_in;
  logic [63:0] dbz_rem;
  logic        is_dbz;
  logic        is_ovf;
  logic        start;

  always_comb begin
    dvd_ext    = div.DIV_dividend;
    dsr_ext    = div.DIV_divisor;
    if (div.DIV_divw) begin
      dvd_ext = {{32{div.DIV_signed & div.DIV_dividend[31]}}, div.DIV_dividend[31:0]};
      dsr_ext = {{32{div.DIV_signed & div.DIV_divisor[31]}}, div.DIV_divisor[31:0]};
    end
    dvd_neg    = div.DIV_signed & dvd_ext[63];
    dsr_neg    = div.DIV_signed & dsr_ext[63];
    dvd_mag_in = dvd_neg ? (64'd0 - dvd_ext) : dvd_ext;
    dsr_mag_in = dsr_neg ? (64'd0 - dsr_ext) : dsr_ext;
    // RV64 sign-extends every W result, the unsigned ones included
    dbz_rem    = div.DIV_divw ? {{32{div.DIV_dividend[31]}}, div.DIV_dividend[31:0]}
                              : div.DIV_dividend;
    is_dbz     = (dsr_ext == 64'd0);
    is_ovf     = div.DIV_signed && (dsr_ext == {64{1'b1}}) &&
                 (dvd_ext == (div.DIV_divw ? 64'hFFFF_FFFF_8000_0000
                                           : 64'h8000_0000_0000_0000));
    start      = (state == IDLE) && div.DIV_valid_in;
  end

  // one restoring step; the remainder always fits 64 bits after restore
  logic [64:0] shifted;
  logic [64:0] trial;
  logic [63:0] rem_nxt;
  logic [63:0] quo_nxt;
  logic [63:0] q_fix;
  logic [63:0] r_fix;
  logic [63:0] q_out;
  logic [63:0] r_out;

  always_comb begin
    shifted = {rem, quo[63]};
    trial   = shifted - {1'b0, dsr_mag};
    rem_nxt = trial[64] ? shifted[63:0] : trial[63:0];
    quo_nxt = {quo[62:0], ~trial[64]};
    q_fix   = neg_q ? (64'd0 - quo_nxt) : quo_nxt;
    r_fix   = neg_r ? (64'd0 - rem_nxt) : rem_nxt;
    q_out   = divw_r ? {{32{q_fix[31]}}, q_fix[31:0]} : q_fix;
    r_out   = divw_r ? {{32{r_fix[31]}}, r_fix[31:0]} : r_fix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (div.DIV_valid_in) state_nxt = (is_dbz || is_ovf) ? DONE : CALC;
      CALC: if (cnt == 6'd0)      state_nxt = DONE;
      DONE:                       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 6'd0;
      rem     <= 64'd0;
      quo     <= 64'd0;
      dsr_mag <= 64'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      divw_r  <= 1'b0;
      q_r     <= 64'd0;
      r_r     <= 64'd0;
    end else begin
      if (start) begin
        if (is_dbz) begin
          q_r <= {64{1'b1}};
          r_r <= dbz_rem;
        end else if (is_ovf) begin
          q_r <= dvd_ext;
          r_r <= 64'd0;
        end else begin
          rem     <= 64'd0;
          // W operands sit in the top half so 32 shifts leave the quotient in [31:0]
          quo     <= div.DIV_divw ? {dvd_mag_in[31:0], 32'd0} : dvd_mag_in;
          dsr_mag <= dsr_mag_in;
          neg_q   <= dvd_neg ^ dsr_neg;
          neg_r   <= dvd_neg;
          divw_r  <= div.DIV_divw;
          cnt     <= div.DIV_divw ? 6'd31 : 6'd63;
        end
      end else if (state == CALC) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        if (cnt == 6'd0) begin
          q_r <= q_out;
          r_r <= r_out;
        end else begin
          cnt <= cnt - 6'd1;
        end
      end
    end
  end

  assign div.DIV_valid_out = (state == DONE);
  assign div.DIV_quotient  = q_r;
  assign div.DIV_remainder = r_r;
  assign div.dbg_state     = state;

endmodule

// File: tb/tb_ysyx_041461_div_iter.sv
// Directed bench for ysyx_041461_div_iter: expected results queued at issue,
// checked by an independent monitor whenever DIV_valid_out fires.
module tb_ysyx_041461_div_iter;
  localparam int W = 160;  // {expected cycle[31:0], quotient[63:0], remainder[63:0]}

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_041461_div_iter_if dif();
  ysyx_041461_div_iter dut (.clk(clk), .rst(rst), .div(dif));

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int           checks   = 0;
  int           failures = 0;
  logic [63:0]  last_q   = 64'd0;
  logic [63:0]  last_r   = 64'd0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && dif.DIV_valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_valid: valid_out=1 at cycle %0d, expected no result", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check64("valid_cycle", 64'(cyc), {32'd0, mon_e[159:128]});
        check64("quotient", dif.DIV_quotient, mon_e[127:64]);
        check64("remainder", dif.DIV_remainder, mon_e[63:0]);
      end
    end
  end

  // driver tasks
  task automatic pulse(input logic sgn, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    dif.DIV_signed   = sgn;
    dif.DIV_divw     = w;
    dif.DIV_dividend = a;
    dif.DIV_divisor  = b;
    dif.DIV_valid_in = 1'b1;
  endtask

  task automatic release_in();
    @(negedge clk);
    dif.DIV_valid_in = 1'b0;
    dif.DIV_signed   = 1'($urandom_range(0, 1));
    dif.DIV_divw     = 1'($urandom_range(0, 1));
    dif.DIV_dividend = {$urandom, $urandom};
    dif.DIV_divisor  = {$urandom, $urandom};
  endtask

  task automatic issue(input logic sgn, input logic w, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] eq, input logic [63:0] er, input int lat);
    pulse(sgn, w, a, b);
    exp_q.push_back({32'(cyc + lat), eq, er});
    last_q = eq;
    last_r = er;
    release_in();
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL timeout: %0d results outstanding after %0d cycles, expected 0", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic run_op(input logic sgn, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eq, input logic [63:0] er, input int lat);
    issue(sgn, w, a, b, eq, er, lat);
    wait_drain(lat + 10);
    repeat (3) @(negedge clk);
    check64("hold_quotient", dif.DIV_quotient, last_q);
    check64("hold_remainder", dif.DIV_remainder, last_r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.DIV_valid_in = 1'b0;
    dif.DIV_signed   = 1'b0;
    dif.DIV_divw     = 1'b0;
    dif.DIV_dividend = 64'd0;
    dif.DIV_divisor  = 64'd0;
    repeat (2) @(negedge clk);
    check64("reset_valid", {63'd0, dif.DIV_valid_out}, 64'd0);
    check64("reset_quotient", dif.DIV_quotient, 64'd0);
    check64("reset_remainder", dif.DIV_remainder, 64'd0);
    check64("reset_state", {62'd0, dif.dbg_state}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 64-bit iterative ops
    run_op(1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
    run_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op(1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
    run_op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 65);
    run_op(1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 65);
    run_op(1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 65);

    // special cases
    run_op(1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1);
    run_op(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 1);

    // W ops
    run_op(1'b0, 1'b1, 64'h1234_5678_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 64'd0, 33);
    run_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0, 1);
    run_op(1'b1, 1'b1, 64'hABCD_0000_FFFF_FFF9, 64'h1234_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op(1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33);
    run_op(1'b1, 1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1);

    // busy: second pulse in cycle 10 is dropped
    issue(1'b0, 1'b0, 64'd1000, 64'd3, 64'd333, 64'd1, 65);
    repeat (8) @(negedge clk);
    pulse(1'b0, 1'b0, 64'd50, 64'd5);
    release_in();
    wait_drain(80);
    repeat (20) @(negedge clk);

    // reset in cycle 20 of an op: outputs clear, no result follows
    pulse(1'b0, 1'b0, 64'd77, 64'd7);
    release_in();
    repeat (18) @(negedge clk);
    check64("pre_reset_quotient", dif.DIV_quotient, 64'd333);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check64("rst_valid", {63'd0, dif.DIV_valid_out}, 64'd0);
    check64("rst_quotient", dif.DIV_quotient, 64'd0);
    check64("rst_remainder", dif.DIV_remainder, 64'd0);
    check64("rst_state", {62'd0, dif.dbg_state}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);

    run_op(1'b0, 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 65);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
